// File: rtl/atomic_counter_reader.sv
// atomic_counter_reader: turns one host read command into an atomic low-word
// beat plus a high-word beat on the 32-bit counter port, tracks in-order acks
// with a timeout, and returns a coherent 64-bit snapshot over valid/ready.
// Optional feature macro: ATOMIC_RD_DELTA_EN (snapshot-to-snapshot delta output).
module atomic_counter_reader #(
    parameter int unsigned ACK_TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rd_valid_i,
    output logic        rd_ready_o,
    output logic        req_o,
    output logic        atomic_o,
    input  logic        ack_i,
    input  logic [31:0] count_i,
    output logic        data_valid_o,
    output logic [63:0] data_o,
    input  logic        data_ready_i,
    output logic [63:0] delta_o,
    output logic        err_o
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned SNAP_W = 64;
    localparam int unsigned TMR_W  = 4;
    localparam int unsigned OUT_W  = 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE_LO = 3'd1,
        ISSUE_HI = 3'd2,
        WAIT     = 3'd3,
        RESP     = 3'd4
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [OUT_W-1:0]   outstanding;
    logic [TMR_W-1:0]   timer;
    logic               got_lo;
    logic [WORD_W-1:0]  lo;

    logic               issue;
    logic               ack_ok;
    logic               stray;
    logic               tmr_en;
    logic               timeout;
    logic               resp_entry;

    logic               rd_ready_d;
    logic               req_d;
    logic               atomic_d;
    logic               data_valid_d;

    // Per-cycle events: beat issue, accepted/stray ack, timer expiry, RESP entry
    always_comb begin
        issue      = (state == ISSUE_LO) || (state == ISSUE_HI);
        ack_ok     = ack_i && (outstanding != '0);
        stray      = ack_i && (outstanding == '0);
        tmr_en     = (outstanding != '0) && !ack_i;
        timeout    = tmr_en && (timer == TMR_W'(ACK_TIMEOUT - 1));
        resp_entry = (state == WAIT) && ack_ok && got_lo;
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; timeout abandons the command from any waiting state
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (rd_valid_i) state_next = ISSUE_LO;
            ISSUE_LO: state_next = ISSUE_HI;
            ISSUE_HI: state_next = timeout ? IDLE : WAIT;
            WAIT: begin
                if (timeout) begin
                    state_next = IDLE;
                end else if (resp_entry) begin
                    state_next = RESP;
                end
            end
            RESP:     if (data_ready_i) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Output decode of the upcoming state, registered below so ports follow the state
    always_comb begin
        rd_ready_d   = 1'b0;
        req_d        = 1'b0;
        atomic_d     = 1'b0;
        data_valid_d = 1'b0;
        case (state_next)
            IDLE:     rd_ready_d   = 1'b1;
            ISSUE_LO: begin
                req_d    = 1'b1;
                atomic_d = 1'b1;
            end
            ISSUE_HI: req_d        = 1'b1;
            RESP:     data_valid_d = 1'b1;
            default:  ;
        endcase
    end

    // Registered state-decode outputs and the one-cycle error pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ready_o   <= 1'b1;
            req_o        <= 1'b0;
            atomic_o     <= 1'b0;
            data_valid_o <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            rd_ready_o   <= rd_ready_d;
            req_o        <= req_d;
            atomic_o     <= atomic_d;
            data_valid_o <= data_valid_d;
            err_o        <= stray || timeout;
        end
    end

    // Outstanding-beat count and no-ack timer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding <= '0;
            timer       <= '0;
        end else begin
            if (timeout) begin
                outstanding <= '0;
            end else begin
                outstanding <= outstanding + OUT_W'(issue) - OUT_W'(ack_ok);
            end
            if (!tmr_en || timeout) begin
                timer <= '0;
            end else begin
                timer <= timer + TMR_W'(1);
            end
        end
    end

    // Ack ordering: first ack of a command is the low word, second the high word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            got_lo <= 1'b0;
            lo     <= '0;
            data_o <= '0;
        end else begin
            if (timeout || (state == IDLE)) begin
                got_lo <= 1'b0;
            end else if (ack_ok) begin
                got_lo <= !got_lo;
            end
            if (timeout) begin
                lo <= '0;
            end else if (ack_ok && !got_lo) begin
                lo <= count_i;
            end
            if (resp_entry) begin
                data_o <= {count_i, lo};
            end
        end
    end

`ifdef ATOMIC_RD_DELTA_EN
    logic [SNAP_W-1:0] prev;
    logic [SNAP_W-1:0] delta_q;

    // Delta against the last handed-off snapshot; wraps modulo 2^64
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev    <= '0;
            delta_q <= '0;
        end else begin
            if (resp_entry) begin
                delta_q <= {count_i, lo} - prev;
            end
            if ((state == RESP) && data_ready_i) begin
                prev <= data_o;
            end
        end
    end

    assign delta_o = delta_q;
`else
    assign delta_o = SNAP_W'(0);
`endif

endmodule

// File: tb/tb_atomic_counter_reader.sv
// Scoreboard bench for atomic_counter_reader: directed reads against a
// counter responder; expected snapshots are queued at command issue and
// checked by an independent response monitor.
`timescale 1ns/1ps
module tb_atomic_counter_reader;

    localparam int unsigned ACK_TIMEOUT = 4;

    logic        clk;
    logic        reset_n;
    logic        rd_valid_i;
    logic        rd_ready_o;
    logic        req_o;
    logic        atomic_o;
    logic        ack_i;
    logic [31:0] count_i;
    logic        data_valid_o;
    logic [63:0] data_o;
    logic        data_ready_i;
    logic [63:0] delta_o;
    logic        err_o;

    int n_cmp;
    int n_fail;

    logic [63:0] exp_data_q[$];
    logic [63:0] exp_delta_q[$];
    logic [63:0] exp_prev;
    logic [63:0] last_data;

    logic        ack_lo_en;
    logic        ack_hi_en;
    logic [31:0] lo_val;
    logic [31:0] hi_val;
    int unsigned stray_req;
    logic [31:0] stray_data;
    int          errs;

    atomic_counter_reader #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rd_valid_i   (rd_valid_i),
        .rd_ready_o   (rd_ready_o),
        .req_o        (req_o),
        .atomic_o     (atomic_o),
        .ack_i        (ack_i),
        .count_i      (count_i),
        .data_valid_o (data_valid_o),
        .data_o       (data_o),
        .data_ready_i (data_ready_i),
        .delta_o      (delta_o),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check(name, 64'(act), 64'(exp));
    endtask

    task automatic push_expect(input logic [31:0] lo, input logic [31:0] hi);
        logic [63:0] snap;
        snap = {hi, lo};
        exp_data_q.push_back(snap);
`ifdef ATOMIC_RD_DELTA_EN
        exp_delta_q.push_back(snap - exp_prev);
`else
        exp_delta_q.push_back(64'd0);
`endif
        exp_prev  = snap;
        last_data = snap;
    endtask

    // Called at a negedge with the DUT idle; returns just after the accept edge
    task automatic do_read(input logic [31:0] lo, input logic [31:0] hi, input bit expect_resp);
        lo_val = lo;
        hi_val = hi;
        check_bit("idle_ready", rd_ready_o, 1'b1);
        if (expect_resp) push_expect(lo, hi);
        rd_valid_i = 1'b1;
        @(posedge clk);
        #1 rd_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(rd_ready_o && !data_valid_o) && (k < 40));
        check_bit("wait_idle_ready", rd_ready_o, 1'b1);
    endtask

    // Counter responder: acks a sampled request one cycle later, or injects a stray ack
    initial begin
        int unsigned seen;
        logic r;
        logic a;
        seen    = 0;
        ack_i   = 1'b0;
        count_i = 32'h0BAD0BAD;
        forever begin
            @(negedge clk);
            r = req_o;
            a = atomic_o;
            @(posedge clk);
            #1;
            if (stray_req != seen) begin
                seen    = stray_req;
                ack_i   = 1'b1;
                count_i = stray_data;
            end else if (r && a && ack_lo_en) begin
                ack_i   = 1'b1;
                count_i = lo_val;
            end else if (r && !a && ack_hi_en) begin
                ack_i   = 1'b1;
                count_i = hi_val;
            end else begin
                ack_i   = 1'b0;
                count_i = 32'h0BAD0BAD;
            end
        end
    end

    // Response monitor: every valid cycle must match the queue head; pop on handshake
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset_n && data_valid_o) begin
                if (exp_data_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got data 0x%0h, want no response", data_o);
                end else begin
                    check("resp_data", data_o, exp_data_q[0]);
                    check("resp_delta", delta_o, exp_delta_q[0]);
                    if (data_ready_i) begin
                        void'(exp_data_q.pop_front());
                        void'(exp_delta_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        n_cmp        = 0;
        n_fail       = 0;
        reset_n      = 1'b0;
        rd_valid_i   = 1'b0;
        data_ready_i = 1'b1;
        ack_lo_en    = 1'b1;
        ack_hi_en    = 1'b1;
        lo_val       = '0;
        hi_val       = '0;
        stray_req    = 0;
        stray_data   = '0;
        exp_prev     = '0;
        last_data    = '0;
        errs         = 0;

        // Reset values
        repeat (2) @(negedge clk);
        check_bit("rst_rd_ready", rd_ready_o, 1'b1);
        check_bit("rst_req", req_o, 1'b0);
        check_bit("rst_atomic", atomic_o, 1'b0);
        check_bit("rst_valid", data_valid_o, 1'b0);
        check_bit("rst_err", err_o, 1'b0);
        check("rst_data", data_o, 64'd0);
        check("rst_delta", delta_o, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single read: beat order and 3-cycle accept-to-valid latency
        do_read(32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
        @(negedge clk);
        check_bit("t1_req_lo", req_o, 1'b1);
        check_bit("t1_atomic_lo", atomic_o, 1'b1);
        check_bit("t1_busy", rd_ready_o, 1'b0);
        @(negedge clk);
        check_bit("t1_req_hi", req_o, 1'b1);
        check_bit("t1_atomic_hi", atomic_o, 1'b0);
        @(negedge clk);
        check_bit("t1_req_wait", req_o, 1'b0);
        check_bit("t1_valid_early", data_valid_o, 1'b0);
        @(negedge clk);
        check_bit("t1_valid", data_valid_o, 1'b1);
        check("t1_data", data_o, 64'h0000_0001_FFFF_FFFE);
        @(negedge clk);
        check_bit("t1_back_idle", rd_ready_o, 1'b1);

        // Back-to-back read: accepted 5 cycles after the previous one
        do_read(32'h9ABC_DEF0, 32'h1234_5678, 1'b1);
        wait_idle();

        // Backpressure: hold data_ready_i low for 6 valid cycles
        data_ready_i = 1'b0;
        do_read(32'h0102_0304, 32'h0A0B_0C0D, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check_bit("bp_busy", rd_ready_o, 1'b0);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_bit("bp_valid", data_valid_o, 1'b1);
            check_bit("bp_ready_low", rd_ready_o, 1'b0);
        end
        @(negedge clk);
        data_ready_i = 1'b1;
        lo_val       = 32'h0000_0ACE;
        hi_val       = 32'h0000_0BEE;
        push_expect(32'h0000_0ACE, 32'h0000_0BEE);
        rd_valid_i   = 1'b1;
        @(negedge clk);
        check_bit("bp_accept_ready", rd_ready_o, 1'b1);
        check_bit("bp_valid_gone", data_valid_o, 1'b0);
        @(posedge clk);
        #1 rd_valid_i = 1'b0;
        @(negedge clk);
        check_bit("bp_next_req", req_o, 1'b1);
        check_bit("bp_next_atomic", atomic_o, 1'b1);
        wait_idle();

        // Timeout: counter never acks
        ack_lo_en = 1'b0;
        ack_hi_en = 1'b0;
        do_read(32'h5555_5555, 32'h6666_6666, 1'b0);
        errs = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (err_o) errs++;
            if (k == 6) begin
                check_bit("to_err_cycle", err_o, 1'b1);
                check_bit("to_idle", rd_ready_o, 1'b1);
            end
            check_bit("to_no_valid", data_valid_o, 1'b0);
        end
        check("to_err_count", 64'(errs), 64'd1);
        ack_lo_en = 1'b1;
        ack_hi_en = 1'b1;
        do_read(32'h0000_0042, 32'h0000_0007, 1'b1);
        wait_idle();

        // Stray ack in IDLE
        stray_data = 32'hDEAD_BEEF;
        stray_req++;
        errs = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (err_o) errs++;
        end
        check("stray_err_count", 64'(errs), 64'd1);
        check("stray_data_hold", data_o, last_data);

        // Reset in WAIT after the low-word ack
        ack_hi_en = 1'b0;
        do_read(32'hAAAA_0001, 32'hBBBB_0002, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_bit("mid_rst_rd_ready", rd_ready_o, 1'b1);
        check_bit("mid_rst_req", req_o, 1'b0);
        check_bit("mid_rst_atomic", atomic_o, 1'b0);
        check_bit("mid_rst_valid", data_valid_o, 1'b0);
        check_bit("mid_rst_err", err_o, 1'b0);
        check("mid_rst_data", data_o, 64'd0);
        check("mid_rst_delta", delta_o, 64'd0);
        @(negedge clk);
        reset_n   = 1'b1;
        ack_hi_en = 1'b1;
        exp_prev  = '0;
        @(negedge clk);

        // Fresh reads after reset; also exercise delta wrap
        do_read(32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1);
        wait_idle();
        do_read(32'h0000_0010, 32'h0000_0000, 1'b1);
        wait_idle();

        check("queue_drained", 64'(exp_data_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
